cpu_div_cell: RTL and testbench

Iterative radix-2 integer divider for the CPU custom-instruction/ALU path; the inverse of the single-cycle multiply cell. It accepts a 32-bit dividend/divisor pair with a start pulse and produces quotient and remainder after a fixed, data-independent latency. Signed and unsigned forms are selected per operation. It sits beside the multiply cell, and the CPU stalls on `busy`.

---
 rtl/cpu_div_pkg.sv | 14 +
 rtl/cpu_div_cell.sv | 165 ++++++++++++++++
 tb/tb_cpu_div_cell.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_div_pkg.sv
// Shared definitions for the iterative radix-2 divider cell.
// Contents: FSM state encoding, default operand width, default counter width.
package cpu_div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/cpu_div_cell.sv
// Iterative restoring radix-2 divider, signed or unsigned per operation.
// Fixed latency of WIDTH+1 cycles from the start edge to the done pulse.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   start           - request, sampled only while idle
//   is_signed       - 1 = two's-complement divide, sampled with start
//   dividend        - numerator, sampled with start
//   divisor         - denominator, sampled with start
//   busy            - operation in progress, start ignored while high
//   done            - one-cycle pulse, results valid from this cycle
//   quotient        - result, held until the next done
//   remainder       - result, held until the next done
//   div_by_zero     - divisor of the last result was zero
module cpu_div_cell
  import cpu_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;          // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operand magnitudes and sign-correction terms
  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? (~dividend + WIDTH'(1)) : dividend;
    b_mag = b_neg ? (~divisor + WIDTH'(1)) : divisor;
    q_fix = q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
    r_fix = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  // Restoring step: since rem < divisor, the WIDTH+1-bit difference's MSB
  // is set exactly when the trial subtract goes negative.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // Next-state and datapath control
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dz_d          = dz_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = CNT_LAST;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dz_d    = (divisor == '0);
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // A zero divisor leaves rem = |dividend|, so the normal remainder
        // fix-up restores the dividend; only the quotient is forced.
        quotient_d    = dz_q ? '1 : q_fix;
        remainder_d   = r_fix;
        div_by_zero_d = dz_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Directed-vector and reference-model bench for cpu_div_cell (WIDTH = 32).
module tb_cpu_div_cell;

  localparam int unsigned W       = 32;
  localparam int          EXP_LAT = 33;
  localparam int          N_RAND  = 300;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  cpu_div_cell #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Launches from a negedge, scrambles operands while busy, waits for done.
  task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                       output int lat, output int busy_n, output logic stable);
    logic [W-1:0] q0;
    q0        = quotient;
    stable    = 1'b1;
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    start     = 1'b0;
    is_signed = ~sgn;
    dividend  = ~a;
    divisor   = b + 32'd3;
    lat       = -1;
    busy_n    = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
      if (quotient !== q0) stable = 1'b0;
      @(negedge clk);
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    logic [W-1:0] q, r, eq, er;
    logic         dz, stable, sgn;
    logic [W-1:0] a, b;
    int           lat, busy_n, nd, first_done;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    vecs[4]  = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[10] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
    vecs[11] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0};
    vecs[12] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
    vecs[13] = '{1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
    vecs[14] = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);

    // Directed table; consecutive ops start in the previous done cycle
    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, dz, lat, busy_n, stable);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(EXP_LAT));
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(EXP_LAT));
      chk($sformatf("v%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), r, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("v%0d_outputs_held", i), 32'(stable), 32'd1);
    end

    // done lasts a single cycle
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    // Second start five cycles into an operation is dropped
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    first_done = -1;
    q = '0;
    r = '0;
    for (int k = 0; k < 75; k++) begin
      if (k == 5) begin
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        nd++;
        if (first_done < 0) begin
          first_done = k;
          q = quotient;
          r = remainder;
        end
      end
      @(negedge clk);
    end
    chk("ignored_start_done_count", 32'(nd), 32'd1);
    chk("ignored_start_latency", 32'(first_done), 32'(EXP_LAT));
    chk("ignored_start_quotient", q, 32'd14);
    chk("ignored_start_remainder", r, 32'd2);

    // Reset at cycle 10 aborts the operation
    start = 1'b1; is_signed = 1'b1; dividend = 32'hFFFFFFF9; divisor = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    count_done(40, nd);
    chk("abort_no_done", 32'(nd), 32'd0);

    do_op(1'b1, 32'd7, 32'hFFFFFFFE, q, r, dz, lat, busy_n, stable);
    chk("post_abort_latency", 32'(lat), 32'(EXP_LAT));
    chk("post_abort_quotient", q, 32'hFFFFFFFD);
    chk("post_abort_remainder", r, 32'd1);

    // Reset beats a simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_vs_start_busy", 32'(busy), 32'd0);
    count_done(40, nd);
    chk("reset_vs_start_no_done", 32'(nd), 32'd0);

    // Random pairs against the reference model
    for (int i = 0; i < N_RAND; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(0, 15));
        2:       b = $urandom >> $urandom_range(0, 31);
        3:       b = ~(32'($urandom_range(0, 15)));
        default: b = 32'd0;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      ref_div(sgn, a, b, eq, er);
      do_op(sgn, a, b, q, r, dz, lat, busy_n, stable);
      n_vec++;
      if (q !== eq || r !== er || dz !== (b == '0) || lat != EXP_LAT) begin
        n_err++;
        $display("FAIL rand%0d s=%0d %h/%h: got q=%h r=%h dz=%0d lat=%0d, expected q=%h r=%h dz=%0d lat=%0d",
                 i, sgn, a, b, q, r, dz, lat, eq, er, (b == '0), EXP_LAT);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
